// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the eth_pkt FIFO read-side logic.
// State encoding, the word-to-byte scale and the default packet size.
package eth_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_PKT_WORDS = 256;

  // Byte count reported to udp_tx; wraps to 16 bits for very large packets.
  function automatic logic [15:0] pkt_byte_num(input int words);
    return 16'(words * BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/eth_down_cnt.sv
// Loadable down-counter that saturates at zero.
// Shared between the WAIT_DONE timeout and the inter-frame gap.
module eth_down_cnt #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/eth_pkt_fifo_reader.sv
// Drains whole packets from eth_pkt_fifo into udp_tx, one word per tx_req.
// Tracks completed packets and raises sticky underflow / timeout flags.
module eth_pkt_fifo_reader
  import eth_pkt_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_WORDS  = DEFAULT_PKT_WORDS,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  input  logic [ADDR_WIDTH:0]   rd_water_level,
  output logic                  tx_start_en,
  output logic [15:0]           tx_byte_num,
  input  logic                  tx_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [15:0]           pkt_cnt,
  output logic                  underflow,
  output logic                  timeout_err
);

  localparam int LVL_W   = ADDR_WIDTH + 1;
  localparam int CNT_MAX = (TIMEOUT > IFG_CYCLES) ? TIMEOUT : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LVL_W-1:0] PKT_LVL   = LVL_W'(PKT_WORDS);
  localparam logic [LVL_W-1:0] LAST_WORD = LVL_W'(PKT_WORDS - 1);
  localparam logic [15:0]      BYTE_NUM  = pkt_byte_num(PKT_WORDS);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IFG_LOAD  = CNT_W'(IFG_CYCLES);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] word_cnt_q, word_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic             underflow_q, underflow_d;
  logic             timeout_q, timeout_d;

  logic             words_left;
  logic             req_ok;
  logic             done_evt;
  logic             to_evt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  // One counter: timeout budget while in WAIT_DONE, inter-frame gap in IDLE.
  eth_down_cnt #(.WIDTH(CNT_W)) u_down_cnt (
    .clk      (rd_clk),
    .rst      (rd_rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign words_left = (word_cnt_q < PKT_LVL);
  assign req_ok     = (state_q == SEND) && tx_req && words_left;
  assign done_evt   = (state_q == WAIT_DONE) && tx_done;
  assign to_evt     = (state_q == WAIT_DONE) && !tx_done && cnt_zero;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (enable && (rd_water_level >= PKT_LVL) && cnt_zero) state_d = START;
      START:     state_d = SEND;
      SEND:      if (req_ok && (word_cnt_q == LAST_WORD)) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done || cnt_zero) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en       = 1'b0;
    tx_start_en = 1'b0;
    busy        = (state_q != IDLE);
    tx_byte_num = busy ? BYTE_NUM : 16'd0;
    unique case (state_q)
      START:   tx_start_en = 1'b1;
      SEND:    rd_en = tx_req && !empty && words_left;
      default: ;
    endcase
    // FIFO has no output register, so rd_data lines up with the cycle after rd_en.
    tx_data = rd_valid_q ? rd_data : '0;
  end

  always_comb begin
    word_cnt_d  = word_cnt_q;
    rd_valid_d  = rd_en;
    pkt_cnt_d   = pkt_cnt_q;
    underflow_d = underflow_q;
    timeout_d   = timeout_q;
    if (state_q == START) begin
      word_cnt_d = '0;
    end else if (req_ok) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
    if (req_ok && empty) underflow_d = 1'b1;
    if (done_evt)        pkt_cnt_d   = pkt_cnt_q + 16'd1;
    if (to_evt)          timeout_d   = 1'b1;
    cnt_load     = done_evt || to_evt || ((state_q == SEND) && (state_d == WAIT_DONE));
    cnt_load_val = (state_q == SEND) ? TO_LOAD : IFG_LOAD;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      word_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      underflow_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      rd_valid_q  <= rd_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      underflow_q <= underflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pkt_cnt     = pkt_cnt_q;
  assign underflow   = underflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_eth_pkt_fifo_reader.sv
// Bench for eth_pkt_fifo_reader: behavioural FIFO + udp_tx model around the DUT,
// with a word scoreboard filled on FIFO writes and drained on tx_data.
module tb_eth_pkt_fifo_reader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int PKT   = 256;
  localparam int IFG   = 12;
  localparam int TO    = 4096;
  localparam int LVL_W = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic             rd_clk = 1'b0;
  logic             rd_rst = 1'b1;
  logic             enable = 1'b0;
  logic             rd_en;
  logic [DW-1:0]    rd_data = '0;
  logic             empty = 1'b1;
  logic [LVL_W-1:0] rd_water_level = '0;
  logic             tx_start_en;
  logic [15:0]      tx_byte_num;
  logic             tx_req = 1'b0;
  logic [DW-1:0]    tx_data;
  logic             tx_done = 1'b0;
  logic             busy;
  logic [15:0]      pkt_cnt;
  logic             underflow;
  logic             timeout_err;

  always #5 rd_clk = ~rd_clk;

  eth_pkt_fifo_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PKT_WORDS  (PKT),
    .IFG_CYCLES (IFG),
    .TIMEOUT    (TO)
  ) dut (
    .rd_clk         (rd_clk),
    .rd_rst         (rd_rst),
    .enable         (enable),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .rd_water_level (rd_water_level),
    .tx_start_en    (tx_start_en),
    .tx_byte_num    (tx_byte_num),
    .tx_req         (tx_req),
    .tx_data        (tx_data),
    .tx_done        (tx_done),
    .busy           (busy),
    .pkt_cnt        (pkt_cnt),
    .underflow      (underflow),
    .timeout_err    (timeout_err)
  );

  logic [DW-1:0] fifo_mem [DEPTH];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] next_word = 32'd1;
  int  wr_ptr, rd_ptr;
  int  cyc, req_left, req_idx, done_wait;
  int  done_delay = 2;
  bit  withhold;
  int  force_lo = -1, force_hi = -1;
  bit  start_seen, rd_en_seen, req_prev, emp_prev, to_seen;
  int  starts, done_cyc, last_req_cyc, rd_pulses, exp_pkt, to_cyc, gap;
  int  n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % DEPTH] = next_word;
      sb.push_back(next_word);
      next_word++;
      wr_ptr++;
    end
    rd_water_level = LVL_W'(wr_ptr - rd_ptr);
    empty          = (wr_ptr == rd_ptr);
  endtask

  // One clock: FIFO read effect and udp_tx stimulus after the edge, DUT sampled at negedge.
  task automatic step(input bit do_rst = 1'b0);
    bit force_now, chk_pend, chk_zero;
    @(posedge rd_clk);
    #1;
    cyc++;
    if (rd_en_seen) begin
      rd_data = fifo_mem[rd_ptr % DEPTH];
      rd_ptr++;
    end
    chk_pend  = req_prev;
    chk_zero  = emp_prev;
    tx_req    = 1'b0;
    tx_done   = 1'b0;
    force_now = 1'b0;
    if (start_seen) begin
      req_left = PKT;
      req_idx  = 0;
    end
    if (req_left > 0) begin
      tx_req    = 1'b1;
      force_now = (req_idx >= force_lo) && (req_idx < force_hi);
      req_left--;
      req_idx++;
      if (req_left == 0) begin
        last_req_cyc = cyc;
        done_wait    = done_delay;
      end
    end else if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0 && !withhold) begin
        tx_done  = 1'b1;
        done_cyc = cyc;
        exp_pkt++;
      end
    end
    empty          = force_now || (wr_ptr == rd_ptr);
    rd_water_level = LVL_W'(wr_ptr - rd_ptr);
    req_prev       = tx_req;
    emp_prev       = empty;
    if (do_rst) begin
      #1;
      rd_rst = 1'b1;
    end
    @(negedge rd_clk);
    if (rd_rst) return;
    if (chk_pend) begin
      if (chk_zero)           check("tx_data_underflow", tx_data, '0);
      else if (sb.size() == 0) check("scoreboard_underrun", sb.size(), 1);
      else                    check("tx_data", tx_data, sb.pop_front());
    end
    check("rd_en", 32'(rd_en), 32'(tx_req && !empty));
    start_seen = tx_start_en;
    if (tx_start_en) begin
      starts++;
      rd_pulses = 0;
      check("tx_byte_num", 32'(tx_byte_num), 32'd1024);
      if (done_cyc > 0) gap = cyc - done_cyc;
    end
    rd_en_seen = rd_en;
    if (rd_en) rd_pulses++;
    if (timeout_err && !to_seen) begin
      to_seen = 1'b1;
      to_cyc  = cyc;
    end
  endtask

  task automatic run_until(input int target_starts, input int budget, input string tag);
    int n = 0;
    while (!(starts >= target_starts && !busy && req_left == 0 && done_wait == 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic reset_models();
    wr_ptr = 0; rd_ptr = 0; sb.delete();
    req_left = 0; req_idx = 0; done_wait = 0;
    start_seen = 1'b0; rd_en_seen = 1'b0; req_prev = 1'b0; emp_prev = 1'b0;
    starts = 0; done_cyc = 0; rd_pulses = 0; exp_pkt = 0; to_seen = 1'b0;
    tx_req = 1'b0; tx_done = 1'b0; empty = 1'b1; rd_water_level = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},       32'(rd_en),       32'd0);
    check({tag, "_tx_start_en"}, 32'(tx_start_en), 32'd0);
    check({tag, "_tx_byte_num"}, 32'(tx_byte_num), 32'd0);
    check({tag, "_tx_data"},     tx_data,          32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_pkt_cnt"},     32'(pkt_cnt),     32'd0);
    check({tag, "_underflow"},   32'(underflow),   32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int n;
    reset_models();
    step(1'b1);
    step();
    check_all_zero("reset");
    rd_rst = 1'b0;
    enable = 1'b1;
    step();

    // 1: single packet of words 1..256
    fill(256);
    run_until(1, 2000, "t1");
    check("t1_starts",    starts, 1);
    check("t1_rd_pulses", rd_pulses, PKT);
    check("t1_pkt_cnt",   32'(pkt_cnt), exp_pkt);
    check("t1_busy",      32'(busy), 32'd0);
    check("t1_sb_left",   sb.size(), 0);

    // 2: one word short of a packet must not start
    fill(255);
    repeat (1000) step();
    check("t2_no_start", starts, 1);
    fill(1);
    n = 0;
    while (starts < 2 && n < 2) begin
      step();
      n++;
    end
    check("t2_start_latency", starts, 2);
    run_until(2, 2000, "t2");
    check("t2_pkt_cnt", 32'(pkt_cnt), exp_pkt);

    // 3: two packets back to back, inter-frame gap honoured
    fill(512);
    run_until(4, 4000, "t3");
    check("t3_starts",  starts, 4);
    check("t3_ifg",     32'(gap >= IFG + 1), 32'd1);
    check("t3_pkt_cnt", 32'(pkt_cnt), exp_pkt);
    check("t3_sb_left", sb.size(), 0);

    // 4: FIFO forced empty for three requests mid-packet
    force_lo = 100;
    force_hi = 103;
    fill(256);
    run_until(5, 2000, "t4");
    force_lo = -1;
    force_hi = -1;
    check("t4_underflow",   32'(underflow), 32'd1);
    check("t4_rd_pulses",   rd_pulses, PKT - 3);
    check("t4_pkt_cnt",     32'(pkt_cnt), exp_pkt);
    check("t4_timeout_err", 32'(timeout_err), 32'd0);
    check("t4_sb_left",     sb.size(), 3);

    // 5: tx_done withheld, timeout after exactly TO cycles in WAIT_DONE
    withhold = 1'b1;
    fill(253);
    run_until(6, 6000, "t5");
    withhold = 1'b0;
    check("t5_timeout_err",  32'(timeout_err), 32'd1);
    check("t5_timeout_time", to_cyc - (last_req_cyc + 1), TO);
    check("t5_pkt_cnt",      32'(pkt_cnt), exp_pkt);
    check("t5_busy",         32'(busy), 32'd0);
    check("t5_underflow",    32'(underflow), 32'd1);
    check("t5_sb_left",      sb.size(), 0);

    // 6: reset asserted during SEND at word 100, then normal operation resumes
    fill(256);
    n = 0;
    while (!(req_idx == 100 && req_left > 0) && n < 600) begin
      step();
      n++;
    end
    check("t6_reach_word100", 32'(n < 600), 32'd1);
    step(1'b1);
    check("t6_tx_req_held", 32'(tx_req), 32'd1);
    check_all_zero("t6_rst");
    reset_models();
    step();
    rd_rst = 1'b0;
    step();
    fill(256);
    run_until(1, 2000, "t6b");
    check("t6b_pkt_cnt",   32'(pkt_cnt), exp_pkt);
    check("t6b_rd_pulses", rd_pulses, PKT);
    check("t6b_underflow", 32'(underflow), 32'd0);
    check("t6b_sb_left",   sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_pkt_fifo_reader.md
Name: eth_pkt_fifo_reader

Overview:
Read-side drain engine for eth_pkt_fifo (32-bit, 2**ADDR_WIDTH deep, OUT_REG=0).
It waits until a whole packet is buffered, then starts the UDP transmitter and hands it one FIFO word per transmitter request.
It sits between the FIFO read port and udp_tx, in the rd_clk domain.
It counts sent packets and flags underflow and transmitter timeout.

Parameters:
ADDR_WIDTH, 10, FIFO address width; water level is ADDR_WIDTH+1 bits.
DATA_WIDTH, 32, FIFO word width (fixed 32; tx_byte_num = words*4).
PKT_WORDS, 256, words per packet; legal range 1..2**ADDR_WIDTH.
IFG_CYCLES, 12, idle cycles enforced between tx_done and the next start.
TIMEOUT, 4096, max cycles in WAIT_DONE before abort.

Ports:
rd_clk  in  1  single clock, shared with the FIFO read side.
rd_rst  in  1  asynchronous, active-high reset.
enable  in  1  permits new packet starts; sampled only in IDLE.
rd_en  out  1  FIFO read strobe.
rd_data  in  DATA_WIDTH  FIFO read data, valid 1 cycle after rd_en.
empty  in  1  FIFO empty.
rd_water_level  in  ADDR_WIDTH+1  FIFO read-side fill level.
tx_start_en  out  1  one-cycle start pulse to udp_tx.
tx_byte_num  out  16  packet byte count, stable from START until IDLE.
tx_req  in  1  udp_tx word request; data is expected on the following cycle.
tx_data  out  DATA_WIDTH  word to udp_tx.
tx_done  in  1  udp_tx end-of-frame pulse.
busy  out  1  high in every state except IDLE.
pkt_cnt  out  16  packets completed.
underflow  out  1  sticky error flag.
timeout_err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; word and gap counters 0.
- IDLE -> START when enable=1, rd_water_level >= PKT_WORDS and gap counter == 0. Otherwise stay in IDLE.
- START, one cycle:
  - tx_start_en=1.
  - tx_byte_num = PKT_WORDS*4, truncated to 16 bits.
  - word_cnt cleared.
  - Go to SEND.
- SEND:
  - rd_en = tx_req & !empty & (word_cnt < PKT_WORDS), combinational.
  - word_cnt increments on every tx_req while word_cnt < PKT_WORDS, whether or not the FIFO was empty.
  - tx_data = rd_data on the cycle after a successful read.
  - tx_data = 0 on the cycle after a tx_req made while empty. That cycle also sets underflow.
  - tx_req while word_cnt == PKT_WORDS is ignored: no rd_en, tx_data = 0.
  - When word_cnt reaches PKT_WORDS, go to WAIT_DONE.
- WAIT_DONE:
  - rd_en is held 0.
  - tx_done=1 -> IDLE; pkt_cnt += 1 (wraps at 16 bits); gap counter loaded with IFG_CYCLES.
  - No tx_done after TIMEOUT cycles -> IDLE; timeout_err set; pkt_cnt unchanged; gap counter loaded.
- tx_done seen in START or SEND is ignored.
- Gap counter decrements by 1 per cycle down to 0.
- Single-word packet (PKT_WORDS=1): SEND is left after the first tx_req.
- Full FIFO (level = 2**ADDR_WIDTH) with PKT_WORDS = 2**ADDR_WIDTH: start is legal.
- The water-level comparison is unsigned and ADDR_WIDTH+1 bits wide.
- Deasserting enable mid-packet has no effect; the current packet completes.
- rd_rst asserted mid-operation:
  - Immediate return to IDLE.
  - rd_en and tx_start_en drop in the same cycle.
  - Sticky flags and pkt_cnt cleared.
- underflow and timeout_err clear only on rd_rst.

Decomposition:
- Shared package eth_pkt_pkg holds:
  - state encoding IDLE=0, START=1, SEND=2, WAIT_DONE=3;
  - localparam BYTES_PER_WORD=4;
  - the default packet size.
- No sub-module is required. The timeout/gap down-counter may be a small shared instance named eth_down_cnt.

Test Plan:
1. Write 256 words 1..256, enable=1, udp_tx model requesting every cycle:
   - one tx_start_en pulse; tx_byte_num=1024;
   - 256 rd_en pulses; tx_data sequence 1..256 with no gaps;
   - after tx_done: pkt_cnt=1, busy=0.
2. Write 255 words:
   - no tx_start_en within 1000 cycles;
   - write 1 more -> start pulse within 2 cycles.
3. Write 512 words, back-to-back packets:
   - second tx_start_en no earlier than 12+1 cycles after the first tx_done;
   - pkt_cnt=2; data continuous 1..512 across both packets.
4. Start a packet, then force empty=1 for 3 requests mid-packet:
   - underflow=1; those 3 tx_data words = 0;
   - word_cnt still reaches 256; WAIT_DONE is entered.
5. Withhold tx_done:
   - timeout_err=1 exactly 4096 cycles after entering WAIT_DONE;
   - return to IDLE; pkt_cnt unchanged.
6. Assert rd_rst during SEND at word 100:
   - rd_en=0 in the same cycle; all outputs 0; state IDLE;
   - after release plus a 256-word refill, normal operation resumes.
